// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding-select and load-use hazard control, driven by a shadow EX/MEM pipeline.
// Selects registered (valid while the consumer sits in EX); stall_if/bubble_ex combinational.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  mem_busy,
  input  logic                  flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall_if,
  output logic                  bubble_ex,
  output logic [CNT_W-1:0]      stall_count
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } ent_t;

  typedef enum logic {RUN, FREEZE} state_t;

  state_t                state_q, state_d;
  ent_t                  ex_q;
  // The WB destination feeds nothing here, so only the fields MEM forwarding needs are kept.
  logic                  mem_valid_q, mem_regwrite_q;
  logic [REG_ADDR_W-1:0] mem_rd_q;
  logic                  pending_q, pending_d;
  logic                  stall_c, bubble_c, adv, ld_id, kill, hazard;
  logic [1:0]            sel_a_c, sel_b_c;

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src);
    if (ex_q.valid && ex_q.regwrite && ex_q.rd != '0 && ex_q.rd == src)
      return 2'b01;
    else if (mem_valid_q && mem_regwrite_q && mem_rd_q != '0 && mem_rd_q == src)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign kill   = flush | pending_q;
  assign hazard = id_valid & ex_q.valid & ex_q.memread & ex_q.regwrite & (ex_q.rd != '0) &
                  ((id_uses_rs & (ex_q.rd == id_rs)) | (id_uses_rt & (ex_q.rd == id_rt)));

  assign sel_a_c = id_uses_rs ? fwd_sel(id_rs) : 2'b00;
  assign sel_b_c = id_uses_rt ? fwd_sel(id_rt) : 2'b00;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    stall_c   = 1'b0;
    bubble_c  = 1'b0;
    adv       = 1'b0;
    ld_id     = 1'b0;
    unique case (state_q)
      RUN:    if (mem_busy) state_d = FREEZE;
      FREEZE: if (!mem_busy) state_d = RUN;
      default: state_d = RUN;
    endcase
    // A FREEZE cycle with mem_busy released is handled exactly like RUN.
    if (mem_busy) begin
      stall_c = 1'b1;
      if (flush) pending_d = 1'b1;
    end else begin
      adv = 1'b1;
      if (kill) begin
        pending_d = 1'b0;
      end else if (hazard) begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
      end else begin
        ld_id = 1'b1;
      end
    end
  end

  assign stall_if  = rst_n & stall_c;
  assign bubble_ex = rst_n & bubble_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      ex_q           <= '0;
      mem_valid_q    <= 1'b0;
      mem_rd_q       <= '0;
      mem_regwrite_q <= 1'b0;
      pending_q      <= 1'b0;
      fwd_a_sel      <= 2'b00;
      fwd_b_sel      <= 2'b00;
      stall_count    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (adv) begin
        mem_valid_q    <= ex_q.valid;
        mem_rd_q       <= ex_q.rd;
        mem_regwrite_q <= ex_q.regwrite;
        if (ld_id) begin
          ex_q      <= '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
          fwd_a_sel <= id_valid ? sel_a_c : 2'b00;
          fwd_b_sel <= id_valid ? sel_b_c : 2'b00;
        end else begin
          ex_q      <= '0;
          fwd_a_sel <= 2'b00;
          fwd_b_sel <= 2'b00;
        end
      end
      if (stall_c && stall_count != {CNT_W{1'b1}})
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding distances, load-use stall, r0, freeze/flush, reset.
module tb_fwd_hazard_ctrl;
  localparam int AW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          mem_busy, flush;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          stall_if, bubble_ex;
  logic [CW-1:0] stall_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .mem_busy(mem_busy), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_if(stall_if), .bubble_ex(bubble_ex), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ALU-style instruction: rd <- f(rs, rt)
  task automatic alu(input int rd, input int rs, input int rt, input bit urs, input bit urt);
    id_valid = 1'b1; id_rd = AW'(rd); id_rs = AW'(rs); id_rt = AW'(rt);
    id_uses_rs = urs; id_uses_rt = urt; id_regwrite = 1'b1; id_memread = 1'b0;
  endtask

  task automatic lw(input int rd, input int rs);
    alu(rd, rs, 0, 1'b1, 1'b0);
    id_memread = 1'b1;
  endtask

  task automatic nop();
    id_valid = 1'b0; id_rd = '0; id_rs = '0; id_rt = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; mem_busy = 1'b0; flush = 1'b0;
    nop();
    #1 rst_n = 1'b0;
    #1;
    chk("reset_a", 32'(fwd_a_sel), 0);
    chk("reset_b", 32'(fwd_b_sel), 0);
    chk("reset_stall", 32'(stall_if), 0);
    chk("reset_bubble", 32'(bubble_ex), 0);
    chk("reset_count", 32'(stall_count), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // distance 1 -> EX/MEM
    alu(3, 1, 2, 1, 1); tick();
    alu(4, 3, 0, 1, 1); tick();
    chk("dist1_a", 32'(fwd_a_sel), 32'h1);
    chk("dist1_b_r0", 32'(fwd_b_sel), 0);
    // distance 2 -> MEM/WB
    alu(3, 1, 2, 1, 1); tick();
    nop(); tick();
    alu(4, 3, 0, 1, 1); tick();
    chk("dist2_a", 32'(fwd_a_sel), 32'h2);
    // distance 3 -> regfile
    alu(3, 1, 2, 1, 1); tick();
    nop(); tick();
    nop(); tick();
    alu(4, 3, 0, 1, 1); tick();
    chk("dist3_a", 32'(fwd_a_sel), 0);

    // load-use
    lw(5, 1); tick();
    chk("lu_count0", 32'(stall_count), 0);
    alu(6, 5, 5, 1, 1); #1;
    chk("lu_stall", 32'(stall_if), 1);
    chk("lu_bubble", 32'(bubble_ex), 1);
    tick();
    chk("lu_bub_sel", 32'(fwd_a_sel), 0);
    chk("lu_stall_gone", 32'(stall_if), 0);
    tick();
    chk("lu_a", 32'(fwd_a_sel), 32'h2);
    chk("lu_b", 32'(fwd_b_sel), 32'h2);
    chk("lu_count1", 32'(stall_count), 1);

    // r0 is never forwarded and never causes a stall
    alu(0, 1, 0, 1, 0); tick();
    alu(1, 0, 0, 1, 1); tick();
    chk("r0_alu_a", 32'(fwd_a_sel), 0);
    chk("r0_alu_b", 32'(fwd_b_sel), 0);
    lw(0, 1); tick();
    alu(2, 0, 0, 1, 1); #1;
    chk("r0_lw_stall", 32'(stall_if), 0);
    tick();
    chk("r0_lw_a", 32'(fwd_a_sel), 0);
    chk("r0_lw_b", 32'(fwd_b_sel), 0);
    chk("r0_count", 32'(stall_count), 1);

    // newest producer wins; unused rt gives 00
    alu(7, 1, 0, 1, 0); tick();
    alu(7, 2, 0, 1, 0); tick();
    alu(8, 7, 7, 1, 0); tick();
    chk("newest_a", 32'(fwd_a_sel), 32'h1);
    chk("unused_b", 32'(fwd_b_sel), 0);

    // memory freeze with a flush pulse in its second cycle
    alu(9, 1, 0, 1, 0); tick();
    alu(10, 9, 0, 1, 0); tick();
    chk("frz_pre_a", 32'(fwd_a_sel), 32'h1);
    alu(11, 10, 0, 1, 0);
    mem_busy = 1'b1; #1;
    chk("frz1_stall", 32'(stall_if), 1);
    chk("frz1_bubble", 32'(bubble_ex), 0);
    tick();
    chk("frz1_a", 32'(fwd_a_sel), 32'h1);
    flush = 1'b1; #1;
    chk("frz2_stall", 32'(stall_if), 1);
    tick();
    flush = 1'b0; #1;
    chk("frz3_stall", 32'(stall_if), 1);
    tick();
    chk("frz3_a", 32'(fwd_a_sel), 32'h1);
    chk("frz_count", 32'(stall_count), 4);
    mem_busy = 1'b0; #1;
    chk("kill_stall", 32'(stall_if), 0);
    chk("kill_bubble", 32'(bubble_ex), 0);
    tick();
    chk("kill_a", 32'(fwd_a_sel), 0);
    alu(12, 10, 0, 1, 0); tick();
    chk("post_kill_a", 32'(fwd_a_sel), 32'h2);
    chk("post_kill_count", 32'(stall_count), 4);

    // reset during a stall with a flush pending
    lw(5, 12); tick();
    chk("rst_pre_a", 32'(fwd_a_sel), 32'h1);
    alu(6, 5, 5, 1, 1);
    mem_busy = 1'b1; flush = 1'b1; #1;
    chk("rst_pre_stall", 32'(stall_if), 1);
    tick();
    chk("rst_pre_count", 32'(stall_count), 5);
    mem_busy = 1'b0; flush = 1'b0; rst_n = 1'b0; #1;
    chk("rst_mid_stall", 32'(stall_if), 0);
    chk("rst_mid_bubble", 32'(bubble_ex), 0);
    chk("rst_mid_a", 32'(fwd_a_sel), 0);
    chk("rst_mid_count", 32'(stall_count), 0);
    rst_n = 1'b1; #1;
    chk("rst_rel_stall", 32'(stall_if), 0);
    tick();
    chk("rst_load_a", 32'(fwd_a_sel), 0);
    alu(14, 6, 0, 1, 0); #1;
    chk("rst_next_stall", 32'(stall_if), 0);
    tick();
    chk("rst_next_a", 32'(fwd_a_sel), 32'h1);
    chk("rst_next_count", 32'(stall_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
